expr_arbiter: RTL and testbench

//  Shares one character-serial expression checker (ports clk/clr/in[7:0]/out; clr sync active-high,
//  out registered = "chars since clr form a valid expression", e.g. "1*2*3") between two requesters.

---
 rtl/expr_arbiter.sv | 171 +++++++++++++++++
 tb/tb_expr_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_arbiter.sv
// ---------------------------------------------------------------------------
// expr_arbiter
//   Shares one character-serial expression checker between two requesters.
//   A requester is granted a whole string at a time (round-robin on ties).
//   The checker is cleared while idle. The string is then fed one char per
//   cycle. The verdict is sampled one cycle after the last char and returned
//   to the owning requester as a single-cycle pulse.
//
//   Optional feature macro: EXPR_ARB_STATS_EN. When it is defined, the
//   cnt_ok / cnt_bad saturating verdict counters are added.
//
// Ports
//   clk        system clock, all state on rising edge
//   clr_n      asynchronous active-low reset
//   req_valid  [i] requester i presents a char
//   req_data   [8i+7:8i] ASCII char of requester i
//   req_last   [i] current char is the last of the string
//   req_ready  [i] char of requester i accepted this cycle
//   res_valid  [i] one-cycle verdict pulse to requester i
//   res_ok     verdict: string is a valid expression
//   res_err    string aborted (bubble or overlength)
//   chk_clr    checker synchronous clear
//   chk_in     checker character input
//   chk_out    checker verdict (registered inside the checker)
//   cnt_ok     (EXPR_ARB_STATS_EN) count of ok verdicts, saturating
//   cnt_bad    (EXPR_ARB_STATS_EN) count of bad/aborted verdicts, saturating
// ---------------------------------------------------------------------------
module expr_arbiter #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = 5
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_last,
    output logic [1:0]  req_ready,
    output logic [1:0]  res_valid,
    output logic        res_ok,
    output logic        res_err,
    output logic        chk_clr,
    output logic [7:0]  chk_in,
    input  logic        chk_out
`ifdef EXPR_ARB_STATS_EN
    ,
    output logic [15:0] cnt_ok,
    output logic [15:0] cnt_bad
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FEED   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    // Length value at which one more accepted non-last char hits MAX_LEN.
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);

    state_t           r_state;
    logic             r_gnt;
    logic             r_rr_ptr;
    logic             r_err;
    logic [LEN_W-1:0] r_len;

    logic             w_gnt_valid;
    logic             w_gnt_last;
    logic [7:0]       w_gnt_data;
    logic             w_next_gnt;

    assign w_gnt_valid = req_valid[r_gnt];
    assign w_gnt_last  = req_last[r_gnt];
    assign w_gnt_data  = r_gnt ? req_data[15:8] : req_data[7:0];
    // Round-robin pointer wins a tie; otherwise whoever is requesting.
    assign w_next_gnt  = req_valid[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= S_IDLE;
            r_gnt    <= 1'b0;
            r_rr_ptr <= 1'b0;
            r_err    <= 1'b0;
            r_len    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req_valid) begin
                        r_gnt   <= w_next_gnt;
                        r_len   <= '0;
                        r_err   <= 1'b0;
                        r_state <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (!w_gnt_valid) begin
                        // The checker has no enable, so a gap corrupts the string.
                        r_err   <= 1'b1;
                        r_state <= S_RESULT;
                    end else if (w_gnt_last) begin
                        r_state <= S_RESULT;
                    end else begin
                        r_len <= r_len + 1'b1;
                        if (r_len == LEN_LAST) begin
                            r_err   <= 1'b1;
                            r_state <= S_RESULT;
                        end
                    end
                end
                S_RESULT: begin
                    r_rr_ptr <= ~r_gnt;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs depend on registered state/grant. In FEED, ready and data pass
    // through from the granted requester only. chk_clr never depends on req_*.
    always_comb begin
        req_ready = '0;
        res_valid = '0;
        res_ok    = 1'b0;
        res_err   = 1'b0;
        chk_clr   = 1'b0;
        chk_in    = '0;
        case (r_state)
            S_IDLE: begin
                chk_clr = 1'b1;
            end
            S_FEED: begin
                chk_in           = w_gnt_data;
                req_ready[r_gnt] = w_gnt_valid;
            end
            S_RESULT: begin
                res_valid[r_gnt] = 1'b1;
                res_err          = r_err;
                res_ok           = chk_out & ~r_err;
            end
            default: begin
                chk_clr = 1'b1;
            end
        endcase
    end

`ifdef EXPR_ARB_STATS_EN
    logic [15:0] r_cnt_ok;
    logic [15:0] r_cnt_bad;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt_ok  <= '0;
            r_cnt_bad <= '0;
        end else if (r_state == S_RESULT) begin
            if (chk_out & ~r_err) begin
                if (r_cnt_ok != '1) begin
                    r_cnt_ok <= r_cnt_ok + 1'b1;
                end
            end else begin
                if (r_cnt_bad != '1) begin
                    r_cnt_bad <= r_cnt_bad + 1'b1;
                end
            end
        end
    end

    assign cnt_ok  = r_cnt_ok;
    assign cnt_bad = r_cnt_bad;
`endif

endmodule

// File: tb/tb_expr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_expr_arbiter
//   Drives two requesters with directed and random strings. A behavioural
//   character-serial checker sits on the chk_* ports. Expected verdicts are
//   computed per string from the expression grammar: single digits separated
//   by '+' or '*'. Those verdicts are queued per requester, and a negedge
//   monitor pops and compares them whenever res_valid pulses.
// ---------------------------------------------------------------------------
module tb_expr_arbiter;

    localparam int unsigned MAXL = 6;

    typedef struct packed {
        logic ok;
        logic err;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [1:0]  res_valid;
    logic        res_ok;
    logic        res_err;
    logic        chk_clr;
    logic [7:0]  chk_in;
    logic        chk_out;
`ifdef EXPR_ARB_STATS_EN
    logic [15:0] cnt_ok;
    logic [15:0] cnt_bad;
`endif

    logic       rv [2];
    logic [7:0] rd [2];
    logic       rl [2];

    assign req_valid = {rv[1], rv[0]};
    assign req_data  = {rd[1], rd[0]};
    assign req_last  = {rl[1], rl[0]};

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   q_order[$];
    int   res_cnt [2];
    int   n_ok = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    expr_arbiter #(
        .MAX_LEN(MAXL),
        .LEN_W  (3)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .res_valid(res_valid),
        .res_ok   (res_ok),
        .res_err  (res_err),
        .chk_clr  (chk_clr),
        .chk_in   (chk_in),
        .chk_out  (chk_out)
`ifdef EXPR_ARB_STATS_EN
        ,
        .cnt_ok   (cnt_ok),
        .cnt_bad  (cnt_bad)
`endif
    );

    // Behavioural checker: 0 = expect digit, 1 = expect operator, 2 = dead.
    int unsigned cs = 0;
    always @(posedge clk) begin
        if (chk_clr) begin
            cs      <= 0;
            chk_out <= 1'b0;
        end else begin
            case (cs)
                0: begin
                    if (chk_in >= "0" && chk_in <= "9") begin
                        cs <= 1; chk_out <= 1'b1;
                    end else begin
                        cs <= 2; chk_out <= 1'b0;
                    end
                end
                1: begin
                    chk_out <= 1'b0;
                    cs      <= (chk_in == "+" || chk_in == "*") ? 0 : 2;
                end
                default: chk_out <= 1'b0;
            endcase
        end
    end

    task automatic chk(input bit good, input string name, input longint act, input longint exp);
        n_checks++;
        if (!good) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Grammar reference: odd length, digits at even positions, ops at odd.
    function automatic bit expr_ok(input string s);
        if (s.len() % 2 == 0) return 1'b0;
        for (int k = 0; k < s.len(); k++) begin
            byte c;
            c = s[k];
            if (k % 2 == 0) begin
                if (!(c >= "0" && c <= "9")) return 1'b0;
            end else begin
                if (!(c == "+" || c == "*")) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    function automatic string rand_str();
        string s;
        int    n;
        bit    good;
        s    = "";
        n    = $urandom_range(1, 8);
        good = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < n; k++) begin
            byte c;
            if (k % 2 == 0) c = 8'("0" + $urandom_range(0, 9));
            else            c = ($urandom_range(0, 1) != 0) ? "*" : "+";
            if (!good && $urandom_range(0, 2) == 0) c = ($urandom_range(0, 1) != 0) ? "a" : "-";
            s = $sformatf("%s%c", s, c);
        end
        return s;
    endfunction

    // Sends string s from requester i; bub >= 0 drops valid after bub chars.
    // Called and returns in the drive phase (just after a rising edge).
    task automatic send(input int i, input string s, input int bub);
        int   n;
        int   start;
        exp_t e;
        n     = s.len();
        start = res_cnt[i];
        if (bub >= 0)     e = '{ok: 1'b0, err: 1'b1};
        else if (n > MAXL) e = '{ok: 1'b0, err: 1'b1};
        else              e = '{ok: expr_ok(s), err: 1'b0};
        if (i == 0) q0.push_back(e); else q1.push_back(e);
        for (int k = 0; k < n; k++) begin
            int t;
            bit got;
            if (k == bub) break;
            rv[i] = 1'b1;
            rd[i] = s[k];
            rl[i] = (k == n - 1);
            if (k == int'(MAXL)) begin
                @(negedge clk);
                chk(req_ready[i] == 1'b0, "overlength_not_ready", req_ready[i], 0);
                @(posedge clk); #1;
                break;
            end
            t   = 0;
            got = 1'b0;
            while (!got) begin
                @(negedge clk);
                got = req_ready[i];
                @(posedge clk); #1;
                t++;
                if (!got && t > 100) begin
                    chk(1'b0, "handshake_timeout", i, k);
                    break;
                end
            end
            if (!got) break;
        end
        rv[i] = 1'b0;
        rl[i] = 1'b0;
        begin
            int t;
            t = 0;
            while (res_cnt[i] == start && t < 60) begin
                @(negedge clk);
                t++;
            end
            if (res_cnt[i] == start) chk(1'b0, "result_timeout", i, start + 1);
            @(posedge clk); #1;
        end
    endtask

    // Monitor / scoreboard.
    logic [1:0] prev_ready = '0;
    logic       prev_clr = 1'b1;
    always @(negedge clk) begin
        if (!clr_n) begin
            n_ok       = 0;
            n_bad      = 0;
            prev_ready = '0;
            prev_clr   = 1'b1;
        end else begin
            if (req_ready == 2'b11) chk(1'b0, "ready_onehot", req_ready, 1);
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i]) begin
                    chk(chk_in == rd[i], "chk_in_data", chk_in, rd[i]);
                    chk(chk_clr == 1'b0, "chk_clr_in_feed", chk_clr, 0);
                end
            end
            if (req_ready != '0 && prev_ready == '0)
                chk(prev_clr == 1'b1, "clr_before_feed", prev_clr, 1);
            if (res_valid == 2'b11) chk(1'b0, "res_valid_onehot", res_valid, 1);
            for (int i = 0; i < 2; i++) begin
                if (res_valid[i]) begin
                    exp_t e;
                    bit   have;
                    have = (i == 0) ? (q0.size() != 0) : (q1.size() != 0);
                    if (!have) begin
                        chk(1'b0, "unexpected_res_valid", i, -1);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk(res_ok == e.ok, "res_ok", res_ok, e.ok);
                        chk(res_err == e.err, "res_err", res_err, e.err);
                        if (e.ok) n_ok++; else n_bad++;
                    end
                    q_order.push_back(i);
                    res_cnt[i]++;
                end
            end
            prev_ready = req_ready;
            prev_clr   = chk_clr;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk(req_ready == '0, {tag, "_ready"}, req_ready, 0);
        chk(res_valid == '0, {tag, "_res_valid"}, res_valid, 0);
        chk(res_ok == 1'b0, {tag, "_res_ok"}, res_ok, 0);
        chk(res_err == 1'b0, {tag, "_res_err"}, res_err, 0);
        chk(chk_clr == 1'b1, {tag, "_chk_clr"}, chk_clr, 1);
        chk(chk_in == 8'h00, {tag, "_chk_in"}, chk_in, 0);
`ifdef EXPR_ARB_STATS_EN
        chk(cnt_ok == 16'd0, {tag, "_cnt_ok"}, cnt_ok, 0);
        chk(cnt_bad == 16'd0, {tag, "_cnt_bad"}, cnt_bad, 0);
`endif
    endtask

    task automatic check_order(input string tag, input int first, input int second);
        chk(q_order.size() == 2, {tag, "_count"}, q_order.size(), 2);
        if (q_order.size() == 2) begin
            chk(q_order[0] == first, {tag, "_first"}, q_order[0], first);
            chk(q_order[1] == second, {tag, "_second"}, q_order[1], second);
        end
    endtask

    initial begin
        rv[0] = 1'b0; rv[1] = 1'b0;
        rd[0] = 8'h00; rd[1] = 8'h00;
        rl[0] = 1'b0; rl[1] = 1'b0;
        res_cnt[0] = 0; res_cnt[1] = 0;
        clr_n = 1'b0;
        #3;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) clr_n = 1'b1;
        @(posedge clk); #1;

        send(0, "1*2*3", -1);
        send(1, "1*2*", -1);

        q_order.delete();
        fork
            send(0, "7+8", -1);
            send(1, "4", -1);
        join
        check_order("tie_after_reset", 0, 1);

        send(0, "1*2*3", 2);

        q_order.delete();
        fork
            send(0, "5", -1);
            send(1, "9*9", -1);
        join
        check_order("tie_round_robin", 1, 0);

        send(0, "1*2*3*4", -1);

        // Abort a string mid-feed with asynchronous reset.
        rv[0] = 1'b1; rd[0] = "1"; rl[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rd[0] = "*";
        @(posedge clk); #1; rd[0] = "2";
        #2 clr_n = 1'b0;
        #1 check_reset_outputs("reset_mid_feed");
        rv[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) clr_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(0, "1*2*3", -1);

        for (int it = 0; it < 40; it++) begin
            bit    use0;
            bit    use1;
            string s0;
            string s1;
            int    b0;
            int    b1;
            use0 = ($urandom_range(0, 3) != 0);
            use1 = ($urandom_range(0, 3) != 0);
            s0   = rand_str();
            s1   = rand_str();
            b0   = -1;
            b1   = -1;
            if ($urandom_range(0, 5) == 0 && s0.len() >= 2 && MAXL >= 2)
                b0 = $urandom_range(1, ((s0.len() < MAXL) ? s0.len() : MAXL) - 1);
            if ($urandom_range(0, 5) == 0 && s1.len() >= 2 && MAXL >= 2)
                b1 = $urandom_range(1, ((s1.len() < MAXL) ? s1.len() : MAXL) - 1);
            fork
                begin if (use0) send(0, s0, b0); end
                begin if (use1) send(1, s1, b1); end
            join
        end

        repeat (4) @(posedge clk);
        #1;
        chk(q0.size() == 0, "q0_drained", q0.size(), 0);
        chk(q1.size() == 0, "q1_drained", q1.size(), 0);
`ifdef EXPR_ARB_STATS_EN
        chk(int'(cnt_ok) == n_ok, "cnt_ok", cnt_ok, n_ok);
        chk(int'(cnt_bad) == n_bad, "cnt_bad", cnt_bad, n_bad);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0t expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule
